// File: rtl/otter_cu_fsm.sv
// Otter RV32I multicycle control FSM: sequences fetch, execute, load write-back
// and interrupt entry by driving the PC, register-file, memory and CSR enables.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   opcode, func3         instruction fields, decoded in EXEC
//   intr                  level interrupt request, pre-masked by mstatus.MIE
//   PCWrite, regWrite     PC and register-file commit enables
//   memWE2                data-memory write enable
//   memRDEN1, memRDEN2    instruction / data memory read enables
//   csr_WE                CSR write enable
//   int_taken, mret_exec  interrupt-entry and MRET strobes to the CSR unit
//   rst_out               copy of RST for the PC and CSR registers

module otter_cu_fsm #(
  parameter int MEM_LAT = 1,
  parameter bit INTR_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  output logic       PCWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       rst_out
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("otter_cu_fsm: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // 3-bit encoding leaves spare codes; any of them recovers to FETCH.
  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    WB    = 3'd2,
    INTR  = 3'd3
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       irq_go;

  // Interrupts are only taken at an instruction's commit cycle.
  assign irq_go = INTR_EN && intr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    PCWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    rst_out   = RST;

    case (state)
      FETCH: begin
        memRDEN1 = 1'b1;
        if (cnt < LAST) begin
          cnt_n = cnt + 4'd1;
        end else begin
          cnt_n   = '0;
          state_n = EXEC;
        end
      end

      EXEC: begin
        cnt_n   = '0;
        state_n = irq_go ? INTR : FETCH;
        case (opcode)
          OP_LOAD: begin
            memRDEN2 = 1'b1;
            state_n  = WB;
          end
          OP_STORE: begin
            memWE2  = 1'b1;
            PCWrite = 1'b1;
          end
          OP_BRANCH: PCWrite = 1'b1;
          OP_OP, OP_IMM, OP_LUI,
          OP_AUIPC, OP_JAL, OP_JALR: begin
            PCWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OP_SYSTEM: begin
            PCWrite = 1'b1;
            if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end else begin
              regWrite = 1'b1;
              csr_WE   = 1'b1;
            end
          end
          default: PCWrite = 1'b1;
        endcase
      end

      WB: begin
        memRDEN2 = 1'b1;
        if (cnt == LAST) begin
          regWrite = 1'b1;
          PCWrite  = 1'b1;
          cnt_n    = '0;
          state_n  = irq_go ? INTR : FETCH;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      INTR: begin
        int_taken = 1'b1;
        PCWrite   = 1'b1;
        cnt_n     = '0;
        state_n   = FETCH;
      end

      default: begin
        cnt_n   = '0;
        state_n = FETCH;
      end
    endcase

    // Reset aborts the cycle: nothing may commit.
    if (RST) begin
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
    end
  end

endmodule
